// File: rtl/qtr_pkg.sv
// Shared types and width helpers for the QTR position sequencer.
package qtr_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHARGE    = 3'd1,
        MEASURE   = 3'd2,
        ACCUM     = 3'd3,
        CHECK     = 3'd4,
        DIV_START = 3'd5,
        DIV_WAIT  = 3'd6,
        DONE      = 3'd7
    } qtr_state_e;

    // Position weight per channel index.
    localparam int unsigned QTR_WEIGHT_STEP_DEF = 1000;

    // Dividend width: time * weight summed over all channels.
    function automatic int unsigned qtr_num_w(input int unsigned cnt_w,
                                              input int unsigned q_w,
                                              input int unsigned n_sens);
        return cnt_w + q_w + $clog2(n_sens);
    endfunction

    // Divisor width: time summed over all channels.
    function automatic int unsigned qtr_den_w(input int unsigned cnt_w,
                                              input int unsigned n_sens);
        return cnt_w + $clog2(n_sens);
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int unsigned qtr_idx_w(input int unsigned n_sens);
        return (n_sens < 2) ? 1 : $clog2(n_sens);
    endfunction

endpackage

// File: rtl/qtr_ch_timer.sv
// Per-channel discharge timer: 2-flop synchroniser, first-low latch and time register.
module qtr_ch_timer
#(
    parameter int unsigned CNT_W = 12
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             meas_en,
    input  logic             tmo,
    input  logic             sen_in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] tmo_val,
    output logic [CNT_W-1:0] t,
    output logic             lat_c
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             lat_q, lat_d;
    logic [CNT_W-1:0] t_q, t_d;

    // Next-state: synchronise the pad, latch the first low sample or the timeout value.
    always_comb begin
        s1_d  = sen_in;
        s2_d  = s1_q;
        lat_d = lat_q;
        t_d   = t_q;
        if (clr) begin
            lat_d = 1'b0;
            t_d   = '0;
        end else if (meas_en && !lat_q) begin
            if (!s2_q) begin
                lat_d = 1'b1;
                t_d   = cnt;
            end else if (tmo) begin
                lat_d = 1'b1;
                t_d   = tmo_val;
            end
        end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lat_q <= 1'b0;
            t_q   <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            lat_q <= lat_d;
            t_q   <= t_d;
        end
    end

    // Latched already, or latching this cycle, so the top can exit without waiting a cycle.
    assign lat_c = lat_q | (meas_en & ~s2_q);
    assign t     = t_q;

endmodule

// File: rtl/qtr_pos_seq.sv
// QTR line-position sequencer: charge, time discharge, weighted sum, external divide.
module qtr_pos_seq
    import qtr_pkg::*;
#(
    parameter int unsigned N_SENS      = 8,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned CHARGE_CYC  = 500,
    parameter int unsigned TIMEOUT_CYC = 2500,
    parameter int unsigned WEIGHT_STEP = QTR_WEIGHT_STEP_DEF,
    parameter int unsigned LOST_THR    = 200,
    parameter int unsigned Q_W         = 16,
    localparam int unsigned NUM_W      = qtr_num_w(CNT_W, Q_W, N_SENS),
    localparam int unsigned DEN_W      = qtr_den_w(CNT_W, N_SENS)
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stp,
    input  logic              cont,
    input  logic [N_SENS-1:0] sen_in,
    output logic [N_SENS-1:0] sen_drv,
    output logic              sen_oe,
    output logic [NUM_W-1:0]  num,
    output logic [DEN_W-1:0]  den,
    output logic              st_div,
    input  logic              eo_div,
    input  logic [Q_W-1:0]    div_q,
    output logic [Q_W-1:0]    pos,
    output logic              pos_valid,
    output logic              lost,
    output logic              eop
);

    localparam int unsigned IDX_W = qtr_idx_w(N_SENS);
    localparam int unsigned CHG_W = $clog2(CHARGE_CYC + 1);
    localparam int unsigned CYC_W = (CHG_W > CNT_W) ? CHG_W : CNT_W;

    qtr_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [DEN_W-1:0]  den_q, den_d;
    logic [Q_W-1:0]    pos_q, pos_d;
    logic              lost_q, lost_d;
    logic [N_SENS-1:0] sen_drv_q, sen_drv_d;
    logic              sen_oe_q, sen_oe_d;
    logic              st_div_q, st_div_d;
    logic              pos_valid_q, pos_valid_d;
    logic              eop_q, eop_d;

    logic [CNT_W-1:0]  t_arr [N_SENS];
    logic [N_SENS-1:0] lat_vec;
    logic              meas_en;
    logic              tmo_hit;
    logic              tmr_clr;
    logic [CNT_W-1:0]  t_sel;
    logic [NUM_W-1:0]  acc_prod;

    assign meas_en = (state_q == MEASURE);
    assign tmo_hit = meas_en && (cnt_q == CYC_W'(TIMEOUT_CYC - 1));
    assign tmr_clr = (state_q == CHARGE);

    // One discharge timer per sensor channel, all sharing the measure counter.
    for (genvar g = 0; g < N_SENS; g++) begin : g_ch
        qtr_ch_timer #(
            .CNT_W   (CNT_W)
        ) u_tmr (
            .clk     (clk),
            .rst     (rst),
            .clr     (tmr_clr),
            .meas_en (meas_en),
            .tmo     (tmo_hit),
            .sen_in  (sen_in[g]),
            .cnt     (CNT_W'(cnt_q)),
            .tmo_val (CNT_W'(TIMEOUT_CYC)),
            .t       (t_arr[g]),
            .lat_c   (lat_vec[g])
        );
    end

    // Weighted term for the channel selected by the accumulate counter.
    always_comb begin
        t_sel    = t_arr[cnt_q[IDX_W-1:0]];
        acc_prod = NUM_W'(t_sel) * NUM_W'(cnt_q[IDX_W-1:0]) * NUM_W'(WEIGHT_STEP);
    end

    // Next-state and datapath updates; registered outputs follow the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        den_d   = den_q;
        pos_d   = pos_q;
        lost_d  = lost_q;

        case (state_q)
            IDLE: begin
                if (stp) begin
                    state_d = CHARGE;
                    cnt_d   = '0;
                    num_d   = '0;
                    den_d   = '0;
                end
            end
            CHARGE: begin
                if (cnt_q == CYC_W'(CHARGE_CYC - 1)) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            MEASURE: begin
                if ((&lat_vec) || tmo_hit) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            ACCUM: begin
                num_d = num_q + acc_prod;
                den_d = den_q + DEN_W'(t_sel);
                if (cnt_q == CYC_W'(N_SENS - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            CHECK: begin
                if (den_q < DEN_W'(LOST_THR)) begin
                    lost_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    lost_d  = 1'b0;
                    state_d = DIV_START;
                end
            end
            DIV_START: begin
                state_d = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (eo_div) begin
                    pos_d   = div_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cont) begin
                    state_d = CHARGE;
                    cnt_d   = '0;
                    num_d   = '0;
                    den_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sen_oe_d    = (state_d == CHARGE);
        sen_drv_d   = sen_oe_d ? '1 : '0;
        st_div_d    = (state_d == DIV_START);
        pos_valid_d = (state_d == DONE);
        eop_d       = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            pos_q       <= '0;
            lost_q      <= 1'b0;
            sen_drv_q   <= '0;
            sen_oe_q    <= 1'b0;
            st_div_q    <= 1'b0;
            pos_valid_q <= 1'b0;
            eop_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            den_q       <= den_d;
            pos_q       <= pos_d;
            lost_q      <= lost_d;
            sen_drv_q   <= sen_drv_d;
            sen_oe_q    <= sen_oe_d;
            st_div_q    <= st_div_d;
            pos_valid_q <= pos_valid_d;
            eop_q       <= eop_d;
        end
    end

    assign sen_drv   = sen_drv_q;
    assign sen_oe    = sen_oe_q;
    assign num       = num_q;
    assign den       = den_q;
    assign st_div    = st_div_q;
    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign lost      = lost_q;
    assign eop       = eop_q;

endmodule

// File: tb/tb_qtr_pos_seq.sv
// Directed bench for qtr_pos_seq: 4 channels, short charge, 100-cycle timeout, 5-cycle divider.
module tb_qtr_pos_seq;

    localparam int unsigned NS    = 4;
    localparam int unsigned NUM_W = 30;
    localparam int unsigned DEN_W = 14;
    localparam int unsigned QW    = 16;
    localparam int          NEVER = 1000;

    logic             clk;
    logic             rst;
    logic             stp;
    logic             cont;
    logic [NS-1:0]    sen_in;
    logic [NS-1:0]    sen_drv;
    logic             sen_oe;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic             st_div;
    logic             eo_div = 1'b0;
    logic [QW-1:0]    div_q  = '0;
    logic [QW-1:0]    pos;
    logic             pos_valid;
    logic             lost;
    logic             eop;

    int n_assert = 0;
    int n_fail   = 0;

    qtr_pos_seq #(
        .N_SENS      (NS),
        .CNT_W       (12),
        .CHARGE_CYC  (4),
        .TIMEOUT_CYC (100),
        .WEIGHT_STEP (1000),
        .LOST_THR    (10),
        .Q_W         (QW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stp       (stp),
        .cont      (cont),
        .sen_in    (sen_in),
        .sen_drv   (sen_drv),
        .sen_oe    (sen_oe),
        .num       (num),
        .den       (den),
        .st_div    (st_div),
        .eo_div    (eo_div),
        .div_q     (div_q),
        .pos       (pos),
        .pos_valid (pos_valid),
        .lost      (lost),
        .eop       (eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: captures num/den on st_div, answers num/den with eo_div five cycles later.
    int               dv_cnt        = 0;
    int               st_div_pulses = 0;
    logic [NUM_W-1:0] dv_num        = '0;
    logic [DEN_W-1:0] dv_den        = '0;

    always @(posedge clk) begin
        eo_div <= 1'b0;
        if (dv_cnt != 0) begin
            if (dv_cnt == 4) begin
                eo_div <= 1'b1;
                div_q  <= QW'(dv_num / NUM_W'(dv_den));
                dv_cnt <= 0;
            end else begin
                dv_cnt <= dv_cnt + 1;
            end
        end else if (st_div) begin
            dv_num        <= num;
            dv_den        <= den;
            dv_cnt        <= 1;
            st_div_pulses <= st_div_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_eop"},     eop,       1);
        chk({tag, "_sen_oe"},  sen_oe,    0);
        chk({tag, "_sen_drv"}, sen_drv,   0);
        chk({tag, "_st_div"},  st_div,    0);
        chk({tag, "_pv"},      pos_valid, 0);
        chk({tag, "_lost"},    lost,      0);
        chk({tag, "_pos"},     pos,       0);
        chk({tag, "_num"},     num,       0);
        chk({tag, "_den"},     den,       0);
    endtask

    task automatic pulse_stp();
        stp = 1'b1;
        @(negedge clk);
        stp = 1'b0;
    endtask

    // Checks the charge phase, then drops channel i so its synchronised bit is low at count t[i].
    // Returns at the first negedge showing st_div or pos_valid; k is cycles since measure start.
    task automatic drive_measure(input int t0, input int t1, input int t2, input int t3,
                                 input bit poke, output int k_end);
        int  tt [4];
        int  n;
        int  k;
        bit  done;
        tt = '{t0, t1, t2, t3};
        n = 0;
        while (!sen_oe && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("charge_start", sen_oe, 1);
        n = 0;
        while (sen_oe && n < 20) begin
            chk("charge_drv", sen_drv, 4'hF);
            @(negedge clk);
            n++;
        end
        chk("charge_len", n, 4);
        chk("meas_oe", sen_oe, 0);
        chk("meas_drv", sen_drv, 0);
        k = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            if (st_div || pos_valid) begin
                done = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (k >= tt[i] - 2) sen_in[i] = 1'b0;
                end
                if (poke && k == 3) stp = 1'b1;
                if (poke && k == 4) stp = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        chk("scan_end_seen", done, 1);
        sen_in = '1;
        k_end  = k;
    endtask

    // Full scan with handshake and result checks; ends on the negedge after the pos_valid cycle.
    task automatic run_scan(input int t0, input int t1, input int t2, input int t3,
                            input bit poke, input int exp_num, input int exp_den,
                            input int exp_pos, input bit exp_lost, input int exp_meas);
        int k;
        int n;
        int pulses0;
        pulses0 = st_div_pulses;
        drive_measure(t0, t1, t2, t3, poke, k);
        if (exp_meas != 0) chk("meas_len", k, exp_meas);
        chk("num", num, exp_num);
        chk("den", den, exp_den);
        if (exp_lost) begin
            chk("lost_st_div", st_div, 0);
            chk("lost_pv", pos_valid, 1);
            chk("lost_flag", lost, 1);
            chk("lost_pos_held", pos, exp_pos);
            @(negedge clk);
            chk("lost_pv_width", pos_valid, 0);
            chk("lost_no_st_div", st_div_pulses, pulses0);
        end else begin
            chk("st_div_hi", st_div, 1);
            @(negedge clk);
            n = 0;
            while (!eo_div && n < 20) begin
                chk("st_div_width", st_div, 0);
                chk("num_hold", num, exp_num);
                chk("den_hold", den, exp_den);
                @(negedge clk);
                n++;
            end
            chk("eo_div_seen", eo_div, 1);
            chk("num_hold_eo", num, exp_num);
            chk("den_hold_eo", den, exp_den);
            @(negedge clk);
            chk("pv", pos_valid, 1);
            chk("pos", pos, exp_pos);
            chk("lost_clear", lost, 0);
            chk("st_div_once", st_div_pulses, pulses0 + 1);
            @(negedge clk);
            chk("pv_width", pos_valid, 0);
        end
    endtask

    initial begin
        int  k;
        bit  pv_seen;
        rst    = 1'b1;
        stp    = 1'b0;
        cont   = 1'b0;
        sen_in = '1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_eop", eop, 1);

        // Valid scan: t=[10,50,50,10] -> num 180000, den 120, pos 1500.
        pulse_stp();
        run_scan(10, 50, 50, 10, 1'b0, 180000, 120, 1500, 1'b0, 0);
        chk("scan1_eop", eop, 1);

        // Lost line: t=[2,2,2,2] -> num 12000, den 8, pos stays 1500.
        pulse_stp();
        run_scan(2, 2, 2, 2, 1'b0, 12000, 8, 1500, 1'b1, 0);
        chk("lost_eop", eop, 1);

        // Reset in MEASURE (stp negedge + 3 charge + 7 measure cycles).
        pulse_stp();
        repeat (10) @(negedge clk);
        chk("pre_rst_meas_oe", sen_oe, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_meas");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_meas_idle", eop, 1);
        chk("rst_meas_oe", sen_oe, 0);

        // Timeout: ch3 never falls -> t3=100; st_div at 100 measure + 4 accum + 1 check cycles.
        pulse_stp();
        run_scan(5, 5, 5, NEVER, 1'b0, 315000, 115, 2739, 1'b0, 105);
        chk("tmo_eop", eop, 1);

        // Reset in DIV_WAIT; the late eo_div must not reach pos.
        pulse_stp();
        drive_measure(10, 50, 50, 10, 1'b0, k);
        chk("rst_div_st_div", st_div, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_div");
        rst = 1'b0;
        pv_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (pos_valid) pv_seen = 1'b1;
        end
        chk("late_eo_pos", pos, 0);
        chk("late_eo_pv", pv_seen, 0);
        chk("late_eo_eop", eop, 1);

        // Continuous mode: one stp, second scan starts straight after DONE.
        cont = 1'b1;
        pulse_stp();
        run_scan(10, 50, 50, 10, 1'b0, 180000, 120, 1500, 1'b0, 0);
        chk("cont_restart_oe", sen_oe, 1);
        chk("cont_restart_eop", eop, 0);
        cont = 1'b0;
        // t=[20,20,60,20] -> num 200000, den 120, pos 1666; stp poked mid-scan is ignored.
        run_scan(20, 20, 60, 20, 1'b1, 200000, 120, 1666, 1'b0, 0);
        chk("cont_stop_eop", eop, 1);
        repeat (5) @(negedge clk);
        chk("cont_stays_idle", eop, 1);
        chk("cont_no_charge", sen_oe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
